// File: rtl/sipo8_if.sv
// Handshake/bus bundle for sipo8_capture: serial input controls plus parallel holding outputs.
// Z0 exists only when SIPO8_ALLONES_EN is defined.
interface sipo8_if;
    logic SI;
    logic SE;
    logic SL;
    logic ACK;
    logic Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
    logic VLD;
    logic OVR;
    logic BUSY;
`ifdef SIPO8_ALLONES_EN
    logic Z0;
`endif

    modport master (
        output SI, SE, SL, ACK,
        input  Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, VLD, OVR, BUSY
`ifdef SIPO8_ALLONES_EN
        , input Z0
`endif
    );

    modport slave (
        input  SI, SE, SL, ACK,
        output Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7, VLD, OVR, BUSY
`ifdef SIPO8_ALLONES_EN
        , output Z0
`endif
    );
endinterface

// File: rtl/sipo8_capture.sv
// 8-bit serial-in/parallel-out capture with valid/ack holding register and sticky overrun.
// Optional macro SIPO8_ALLONES_EN adds Z0, a registered AND of the holding bits.
module sipo8_capture #(
    parameter bit         MSB_FIRST = 1'b0,
    parameter logic [7:0] INIT_VAL  = 8'h00
) (
    input logic     CK,
    input logic     CDN,
    sipo8_if.slave  bus
);

    logic [7:0] shreg;
    logic [7:0] hold;
    logic [7:0] assembled;
    logic [2:0] cnt;
    logic       vld;
    logic       ovr;
    logic       busy;
    logic       completing;
`ifdef SIPO8_ALLONES_EN
    logic       z0;
`endif

    // Byte as it will look after this edge's shift, including the current SI.
    assign assembled  = MSB_FIRST ? {shreg[6:0], bus.SI} : {bus.SI, shreg[7:1]};
    assign completing = bus.SE && !bus.SL && (cnt == 3'd7);

    // NOTE: every register here, state and outputs alike, is assigned with <= so
    // all updates see pre-edge values; the async reset clears each of them.
    always_ff @(posedge CK or negedge CDN) begin
        if (!CDN) begin
            shreg <= INIT_VAL;
            hold  <= INIT_VAL;
            cnt   <= 3'd0;
            vld   <= 1'b0;
            ovr   <= 1'b0;
            busy  <= 1'b0;
`ifdef SIPO8_ALLONES_EN
            z0    <= &INIT_VAL;
`endif
        end else begin
            if (bus.SL) begin
                cnt   <= 3'd0;
                shreg <= INIT_VAL;
                busy  <= 1'b0;
            end else if (bus.SE) begin
                shreg <= assembled;
                cnt   <= cnt + 3'd1;
                busy  <= (cnt != 3'd7);
            end

            // A completing edge with an ACK frees the holding register and refills it.
            if (completing && (!vld || bus.ACK)) begin
                hold <= assembled;
                vld  <= 1'b1;
`ifdef SIPO8_ALLONES_EN
                z0   <= &assembled;
`endif
            end else if (completing) begin
                ovr <= 1'b1;
            end else if (bus.ACK) begin
                vld <= 1'b0;
            end
        end
    end

    assign bus.Q0   = hold[0];
    assign bus.Q1   = hold[1];
    assign bus.Q2   = hold[2];
    assign bus.Q3   = hold[3];
    assign bus.Q4   = hold[4];
    assign bus.Q5   = hold[5];
    assign bus.Q6   = hold[6];
    assign bus.Q7   = hold[7];
    assign bus.VLD  = vld;
    assign bus.OVR  = ovr;
    assign bus.BUSY = busy;
`ifdef SIPO8_ALLONES_EN
    assign bus.Z0   = z0;
`endif

endmodule

// File: tb/tb_sipo8_capture.sv
// Directed bench for sipo8_capture: one LSB-first and one MSB-first instance fed the same bytes,
// each in its own bit order, so both must present the same holding value.
module tb_sipo8_capture;

    logic CK;
    logic CDN;
    int   errors;
    int   checks;

    sipo8_if if_l ();
    sipo8_if if_m ();

    sipo8_capture #(.MSB_FIRST(1'b0), .INIT_VAL(8'h00)) dut_l (.CK(CK), .CDN(CDN), .bus(if_l));
    sipo8_capture #(.MSB_FIRST(1'b1), .INIT_VAL(8'h00)) dut_m (.CK(CK), .CDN(CDN), .bus(if_m));

    logic [7:0] q_l;
    logic [7:0] q_m;
    assign q_l = {if_l.Q7, if_l.Q6, if_l.Q5, if_l.Q4, if_l.Q3, if_l.Q2, if_l.Q1, if_l.Q0};
    assign q_m = {if_m.Q7, if_m.Q6, if_m.Q5, if_m.Q4, if_m.Q3, if_m.Q2, if_m.Q1, if_m.Q0};

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_both(input string tag, input logic [7:0] q, input logic vld,
                            input logic ovr, input logic busy);
        chk({tag, " lsb Q"},    q_l,       q);
        chk({tag, " lsb VLD"},  if_l.VLD,  vld);
        chk({tag, " lsb OVR"},  if_l.OVR,  ovr);
        chk({tag, " lsb BUSY"}, if_l.BUSY, busy);
        chk({tag, " msb Q"},    q_m,       q);
        chk({tag, " msb VLD"},  if_m.VLD,  vld);
        chk({tag, " msb OVR"},  if_m.OVR,  ovr);
        chk({tag, " msb BUSY"}, if_m.BUSY, busy);
    endtask

    // Sends bits lo..hi of b: LSB-first to if_l, MSB-first to if_m.
    task automatic send_bits(input logic [7:0] b, input int lo, input int hi, input bit ack_last);
        for (int i = lo; i <= hi; i++) begin
            if_l.SI  = b[i];
            if_m.SI  = b[7-i];
            if_l.SE  = 1'b1;
            if_m.SE  = 1'b1;
            if_l.ACK = ack_last && (i == hi);
            if_m.ACK = ack_last && (i == hi);
            @(posedge CK); #1;
        end
        if_l.SE  = 1'b0;
        if_m.SE  = 1'b0;
        if_l.ACK = 1'b0;
        if_m.ACK = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input bit ack, input bit sl);
        for (int i = 0; i < n; i++) begin
            if_l.ACK = ack;
            if_m.ACK = ack;
            if_l.SL  = sl;
            if_m.SL  = sl;
            @(posedge CK); #1;
        end
        if_l.ACK = 1'b0;
        if_m.ACK = 1'b0;
        if_l.SL  = 1'b0;
        if_m.SL  = 1'b0;
    endtask

    task automatic do_reset();
        CDN = 1'b0;
        #2;
        CDN = 1'b1;
        @(posedge CK); #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        CDN = 1'b0;
        {if_l.SI, if_l.SE, if_l.SL, if_l.ACK} = 4'b0;
        {if_m.SI, if_m.SE, if_m.SL, if_m.ACK} = 4'b0;
        #1;
        chk_both("reset", 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef SIPO8_ALLONES_EN
        chk("reset Z0", if_l.Z0, 1'b0);
`endif
        @(posedge CK); #1;
        CDN = 1'b1;

        // Stream 1,0,1,0,0,1,0,1 gives A5 in both bit orders.
        send_bits(8'hA5, 0, 6, 1'b0);
        chk_both("A5 seven bits", 8'h00, 1'b0, 1'b0, 1'b1);
        send_bits(8'hA5, 7, 7, 1'b0);
        chk_both("A5 capture", 8'hA5, 1'b1, 1'b0, 1'b0);

        // Async reset mid-frame while VLD=1, checked before any clock edge.
        send_bits(8'h55, 0, 2, 1'b0);
        chk_both("pre reset", 8'hA5, 1'b1, 1'b0, 1'b1);
        CDN = 1'b0;
        #1;
        chk_both("async reset", 8'h00, 1'b0, 1'b0, 1'b0);
        #1;
        CDN = 1'b1;
        @(posedge CK); #1;

        // Back-to-back bytes without ACK: second is dropped.
        send_bits(8'h0F, 0, 7, 1'b0);
        chk_both("0F capture", 8'h0F, 1'b1, 1'b0, 1'b0);
        send_bits(8'hF0, 0, 7, 1'b0);
        chk_both("overrun", 8'h0F, 1'b1, 1'b1, 1'b0);
        idle_cycles(1, 1'b1, 1'b0);
        chk_both("ovr sticky", 8'h0F, 1'b0, 1'b1, 1'b0);

        // Same again with ACK on the second completing edge.
        do_reset();
        send_bits(8'h0F, 0, 7, 1'b0);
        send_bits(8'hF0, 0, 7, 1'b1);
        chk_both("ack on complete", 8'hF0, 1'b1, 1'b0, 1'b0);
        idle_cycles(1, 1'b1, 1'b0);
        chk_both("ack clears", 8'hF0, 1'b0, 1'b0, 1'b0);
        idle_cycles(1, 1'b1, 1'b0);
        chk_both("ack idle", 8'hF0, 1'b0, 1'b0, 1'b0);

        // Resync after 5 bits; SL overrides SE with SI=1 held.
        send_bits(8'hFF, 0, 4, 1'b0);
        if_l.SE = 1'b1;
        if_m.SE = 1'b1;
        if_l.SI = 1'b1;
        if_m.SI = 1'b1;
        idle_cycles(1, 1'b0, 1'b1);
        if_l.SE = 1'b0;
        if_m.SE = 1'b0;
        chk_both("resync", 8'hF0, 1'b0, 1'b0, 1'b0);
        send_bits(8'h3C, 0, 7, 1'b0);
        chk_both("3C after resync", 8'h3C, 1'b1, 1'b0, 1'b0);

        // Stall mid-frame for 10 cycles, acknowledging 3C meanwhile.
        send_bits(8'h96, 0, 2, 1'b0);
        idle_cycles(1, 1'b1, 1'b0);
        idle_cycles(9, 1'b0, 1'b0);
        chk_both("stall", 8'h3C, 1'b0, 1'b0, 1'b1);
        send_bits(8'h96, 3, 7, 1'b0);
        chk_both("96 after stall", 8'h96, 1'b1, 1'b0, 1'b0);

`ifdef SIPO8_ALLONES_EN
        do_reset();
        send_bits(8'hFF, 0, 7, 1'b0);
        chk("FF Z0", if_l.Z0, 1'b1);
        chk("FF VLD", if_l.VLD, 1'b1);
        chk("FF msb Z0", if_m.Z0, 1'b1);
        send_bits(8'hFE, 0, 7, 1'b1);
        chk("FE Z0", if_l.Z0, 1'b0);
        chk("FE Q", q_l, 8'hFE);
        chk("FE msb Z0", if_m.Z0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish expected finish before 50000");
        $fatal(1, "timeout");
    end

endmodule
